// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: sequential W-bit adder that processes one 16-bit slice per
// clock with a two-level carry-lookahead slice datapath.
// W = 16*SLICES. An IDLE/RUN/DONE controller latches the operands and walks the
// slice index k. Each slice's carry-out is registered and fed into the next slice.
// The result registers sum/cout/ovf are loaded only on the completion edge or cleared by reset.
// Optional feature macro: ADD_SUB_EN. When it is defined, the port sub exists.
// With sub=1 the block computes a-b by latching ~b as operand B and forcing the carry-in to 1.
module cla_seq_adder_ctrl #(
  parameter  int SLICES = 4,
  localparam int W      = 16 * SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Controller and datapath state
  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     carry_q, carry_d;
  logic [SLICES-1:0][15:0]  a_q, a_d;
  logic [SLICES-1:0][15:0]  b_q, b_d;
  logic [SLICES-1:0][15:0]  acc_q, acc_d;
  logic [W-1:0]             sum_q, sum_d;
  logic                     cout_q, cout_d;
  logic                     ovf_q, ovf_d;

  // Effective operand B and carry-in, as seen at acceptance
  logic [W-1:0] b_eff;
  logic         cin_eff;

`ifdef ADD_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // ---------------------------------------------------------------------------
  // Slice datapath: the 16-bit slice k of the latched operands, with a
  // two-level carry lookahead.
  // ---------------------------------------------------------------------------
  logic [15:0] sl_a, sl_b;   // current slice operands
  logic [15:0] p, g;         // bit propagate / generate
  logic [15:0] c;            // carry into each bit of the slice
  logic [3:0]  gp, gg;       // group propagate / generate
  logic [3:0]  cg;           // carry into each 4-bit group
  logic        c_out16;      // carry out of the slice
  logic [15:0] slice_sum;

  assign sl_a = a_q[k_q];
  assign sl_b = b_q[k_q];
  assign p    = sl_a ^ sl_b;
  assign g    = sl_a & sl_b;

  // First level: each 4-bit group computes its own internal carries.
  // It also produces the block P/G terms. The group's carry-in cg comes from
  // the second-level unit, never from the neighbouring group.
  for (genvar gi = 0; gi < 4; gi++) begin : g_group
    localparam int B = 4 * gi;

    assign gp[gi] = p[B+3] & p[B+2] & p[B+1] & p[B];
    assign gg[gi] = g[B+3]
                  | (p[B+3] & g[B+2])
                  | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);

    assign c[B]   = cg[gi];
    assign c[B+1] = g[B] | (p[B] & cg[gi]);
    assign c[B+2] = g[B+1]
                  | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & cg[gi]);
    assign c[B+3] = g[B+2]
                  | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & cg[gi]);
  end

  // Second level: the group carries come straight from the stored carry and
  // the group P/G terms.
  assign cg[0]   = carry_q;
  assign cg[1]   = gg[0] | (gp[0] & carry_q);
  assign cg[2]   = gg[1]
                 | (gp[1] & gg[0])
                 | (gp[1] & gp[0] & carry_q);
  assign cg[3]   = gg[2]
                 | (gp[2] & gg[1])
                 | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & carry_q);
  assign c_out16 = gg[3]
                 | (gp[3] & gg[2])
                 | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & carry_q);

  assign slice_sum = p ^ c;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------

  // Next-state and datapath-update logic; every register holds by default
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = cin_eff;
          k_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d[k_q] = slice_sum;
        carry_d    = c_out16;
        if (k_q == K_LAST) begin
          // acc_d already holds the final slice, so the full result is here.
          sum_d   = acc_d;
          cout_d  = c_out16;
          // c[15] is the carry into bit W-1 when this is the top slice.
          ovf_d   = c[15] ^ c_out16;
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status outputs decode directly from the state register
  always_comb begin
    busy = (state_q == RUN) || (state_q == DONE);
    done = (state_q == DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Scoreboard bench for cla_seq_adder_ctrl.
// The driver issues operations and pushes the expected results, which are
// computed with plain W-bit arithmetic. A monitor compares each done pulse
// against the queue. It also checks that the result registers hold between
// completions.
module tb_cla_seq_adder_ctrl;
  localparam int SLICES = 4;
  localparam int W      = 16 * SLICES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
`ifdef ADD_SUB_EN
  logic         sub;
`endif
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  cla_seq_adder_ctrl #(.SLICES(SLICES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t exp_q[$];
  exp_t hold   = '0;
  int   n_vec  = 0;
  int   n_err  = 0;
  bit   mon_en = 1'b0;
  logic rst_seen = 1'b0;

  // Reference model. The result is the W-bit sum with its carry out.
  // Overflow occurs when both addends share a sign that the result lacks.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xci, input logic xsub);
    logic [W-1:0] bb;
    logic         ci;
    logic [W:0]   full;
    exp_t         r;
    bb     = xsub ? ~xb : xb;
    ci     = xsub ? 1'b1 : xci;
    full   = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, ci};
    r.s    = full[W-1:0];
    r.c    = full[W];
    r.o    = (xa[W-1] == bb[W-1]) && (r.s[W-1] != xa[W-1]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      2:       v = {1'b0, {(W-1){1'b1}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Track whether the last clock edge was a reset edge
  always @(posedge clk) rst_seen <= rst;

  // Monitor: score every done pulse and check that results hold between pulses
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) hold = '0;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got sum %h with no pending request at %0t", sum, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", {sum, cout, ovf}, e);
          hold = e;
        end
      end else begin
        chk("hold", {sum, cout, ovf}, hold);
      end
    end
  end

  // Run one operation from an IDLE negedge.
  // With glitch set, a second start with other operands is raised while busy.
  // A nonzero rst_at asserts reset in that RUN cycle (1 = first RUN cycle).
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tci, input logic tsb, input bit glitch,
                        input int rst_at);
    int  busy_cnt, done_cnt, lat, guard;
    bit  finished;
    logic xsub;
    guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk("idle_timeout", {{(W+1){1'b0}}, busy}, '0);
`ifdef ADD_SUB_EN
    xsub = tsb;
    sub  = tsb;
`else
    xsub = 1'b0 & tsb;
`endif
    a = ta; b = tb_v; cin = tci; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (rst_at == 0) exp_q.push_back(model(ta, tb_v, tci, xsub));
    // Operands are latched, so scramble the inputs while the operation runs.
    a = rnd_op(); b = rnd_op(); cin = 1'($urandom);
`ifdef ADD_SUB_EN
    sub = 1'($urandom);
`endif
    busy_cnt = 0; done_cnt = 0; lat = -1; finished = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (rst_at != 0 && cyc == rst_at + 1) begin
        chk("rst_busy", {{(W+1){1'b0}}, busy}, '0);
        chk("rst_done", {{(W+1){1'b0}}, done}, '0);
        chk("rst_result", {sum, cout, ovf}, '0);
        rst = 1'b0;
        finished = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = cyc;
      end
      start = (glitch && cyc == 2) ? 1'b1 : 1'b0;
      if (glitch && cyc == 2) begin
        a = rnd_op(); b = rnd_op();
      end
      if (rst_at != 0 && cyc == rst_at) rst = 1'b1;
      if (!busy && rst_at == 0) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      chk("op_timeout", {{(W+1){1'b0}}, finished}, {{(W+1){1'b0}}, 1'b1});
    end else if (rst_at == 0) begin
      chk("busy_cycles", (W+2)'(busy_cnt), (W+2)'(SLICES + 1));
      chk("done_pulses", (W+2)'(done_cnt), (W+2)'(1));
      chk("done_latency", (W+2)'(lat), (W+2)'(SLICES + 1));
    end
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {{(W+1){1'b0}}, busy}, '0);
    chk("reset_done", {{(W+1){1'b0}}, done}, '0);
    chk("reset_result", {sum, cout, ovf}, '0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Full ripple through every slice
    run_op({W{1'b1}}, 64'h1, 1'b0, 1'b0, 1'b0, 0);
    // Signed overflow
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 0);
    // Carry across a slice boundary from carry-in
    run_op(64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b0, 0);
    // Start while busy must be ignored
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1'b1, 0);
    // Reset in the third RUN cycle, then a clean operation
    run_op(64'hDEAD_BEEF_0000_1111, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b0, 3);
    run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 1'b0, 0);
`ifdef ADD_SUB_EN
    run_op(64'd5, 64'd7, 1'b0, 1'b1, 1'b0, 0);
    run_op(64'd7, 64'd5, 1'b0, 1'b1, 1'b0, 0);
`endif
    for (int i = 0; i < 60; i++) begin
      run_op(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0), 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", (W+2)'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder_ctrl.md
CLA_SEQ_ADDER_CTRL -- requirements
Module: cla_seq_adder_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: port clk is the clock and port rst is the reset.
REQ-002 Parameter SLICES, default 4: number of 16-bit slices; operand width W = 16*SLICES.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a new addition; sampled only in IDLE.
REQ-006 a  input  W  operand A, captured on accepted start.
REQ-007 b  input  W  operand B, captured on accepted start.
REQ-008 cin  input  1  carry-in, captured on accepted start.
REQ-009 sub  input  1  subtract request, captured on accepted start; present only when ADD_SUB_EN is defined.
REQ-010 busy  output  1  high in RUN and DONE states.
REQ-011 done  output  1  single-cycle pulse when the result becomes valid.
REQ-012 sum  output  W  registered result, held until the next completion.
REQ-013 cout  output  1  carry out of bit W-1.
REQ-014 ovf  output  1  signed overflow: carry into bit W-1 XOR carry out of bit W-1.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE after slice SLICES-1; DONE->IDLE unconditionally.
REQ-016 On the edge where start=1 in IDLE, the block SHALL latch a, b, cin (and sub), clear slice index k to 0, load the carry register with the effective carry-in, and enter RUN.
REQ-017 In RUN, each cycle SHALL process slice k (bits 16k+15:16k) combinationally, then on the edge store the slice sum into the internal accumulator, update the carry register, and increment k.
REQ-018 The slice datapath SHALL compute the 16-bit slice with two-level carry lookahead: bitwise P=a^b and G=a&b; four 4-bit groups each producing internal carries plus block P/G; and a second-level 4-group lookahead unit producing the group carries from the stored carry. Ripple chaining between groups is prohibited.
REQ-019 On the edge that finishes slice SLICES-1, the block SHALL write sum, cout and ovf from the accumulator and final carries, and enter DONE.
REQ-020 done SHALL be 1 for exactly the one cycle spent in DONE; with SLICES=4, start accepted at edge T0 gives done high in the cycle after edge T4 (latency 4 edges to result).
REQ-021 start SHALL be ignored in RUN and DONE; operands SHALL be latched, so changes to a, b, cin or sub after acceptance have no effect.
REQ-022 Minimum spacing between accepted starts SHALL be SLICES+2 cycles; start held high continuously SHALL be re-accepted in the first IDLE cycle.
REQ-023 sum, cout and ovf SHALL change only on the completion edge or on reset, and are otherwise held.
REQ-024 Arithmetic SHALL be modulo 2^W; cout carries the bit-W result.

Reset
REQ-025 With rst=1 at a clock edge, the block SHALL enter IDLE, set k=0, clear the carry register and accumulator, set busy=0, done=0, sum=0, cout=0 and ovf=0; this applies in any state.
REQ-026 A reset during RUN SHALL abort the operation with no done pulse; start is not sampled on a reset edge.

Configuration
REQ-027 Macro ADD_SUB_EN: when defined, port sub exists; sub=1 at acceptance SHALL latch ~b as operand B and force the effective carry-in to 1, ignoring cin, so the result is a-b; sub=0 behaves as addition.
REQ-028 When ADD_SUB_EN is undefined, port sub SHALL be absent and the block SHALL perform addition only, with carry-in equal to cin.

Verification
REQ-029 Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x0, cout=1, ovf=0; done exactly 5 cycles after the start edge cycle.
REQ-030 Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-031 Slice-boundary carry: a=0x0000_0000_FFFF_FFFF, b=0x0, cin=1 -> sum=0x0000_0001_0000_0000, cout=0.
REQ-032 Busy rejection: start a second request with different operands 2 cycles after acceptance -> first result only, one done pulse; busy stays high for 5 cycles.
REQ-033 Reset mid-op: assert rst in the third RUN cycle -> next cycle busy=0, done never pulses, sum=0; a following start completes correctly.
REQ-034 With ADD_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; a=7, b=5, sub=1 -> sum=2, cout=1.
